pe_maxpool2x2: RTL
==================

# pe_maxpool2x2

Streaming 2×2/stride-2 max-pooling stage directly downstream of the processing element. It consumes the PE's saturated 8-bit signed result stream (`out`/`out_en`) in raster order, one feature-map row at a time. It emits one pooled value per 2×2 window. Pooling is done on the fly with a half-row line buffer, so no full-frame storage is needed.

## Interface
Parameters:
- `DATA_W`, 8 — sample width, signed two's complement; matches PE `outport`.
- `MAX_COLS`, 64 — maximum feature-map width in samples; must be even.
- `COL_W`, 7 — width of column configuration and counter; must satisfy `2^COL_W > MAX_COLS`.

Ports:
- `clk`, input, 1 — clock.
- `reset`, input, 1 — synchronous, active-low.
- `cfg_start`, input, 1 — single-cycle pulse; latches `cfg_cols` and clears all position state.
- `cfg_cols`, input, COL_W — feature-map width in samples.
- `in_data`, input, DATA_W — signed sample; driven by PE `out`.
- `in_valid`, input, 1 — sample qualifier; driven by PE `out_en`.
- `out_data`, output, DATA_W — signed pooled value.
- `out_valid`, output, 1 — one-cycle pulse per pooled value.
- `out_row_last`, output, 1 — asserted together with `out_valid` on the last pooled value of an output row.

## Operation
**Width handling.** Effective width `W = cfg_cols & ~1`, clamped to the range [2, MAX_COLS]. `W` is latched on `cfg_start`.

**Position state:**
- `col`: 0..W-1.
- `row_odd`: 1 bit.
- `hold`: DATA_W register holding the first sample of a horizontal pair.
- `lbuf`: register array of MAX_COLS/2 × DATA_W entries, indexed by `col>>1`.

**Per accepted sample `x`** (`in_valid=1`):
- `col` even: `hold <= x`.
- `col` odd: `p = smax(hold, x)`, where `smax` is a signed maximum.
  - Even row: `lbuf[col>>1] <= p`.
  - Odd row: `out_data <= smax(p, lbuf[col>>1])`, `out_valid <= 1`, and `out_row_last <= (col == W-1)`.
- Position advance: `col` increments. When `col == W-1`, `col` wraps to 0 and `row_odd` toggles.

**Cycle rules:**
- Cycles with `in_valid=0` change no state except clearing `out_valid` and `out_row_last`. Gaps of any length between samples are legal.
- `cfg_start` with `in_valid=1` in the same cycle: the clear takes effect and the sample is accepted as column 0 of row 0 under the new `W`.
- `cfg_start` mid-row: the partial window is discarded and no output is produced for it. `lbuf` contents are not cleared; they are overwritten by the next even row before being read.

**Status.** There is no frame-end or row-count limit. Pooling continues indefinitely until the next `cfg_start`.

## Timing
- Reset (`reset=0` at a clk edge) sets:
  - `out_data=0`, `out_valid=0`, `out_row_last=0`.
  - `col=0`, `row_odd=0`, `hold=0`.
  - `W=2`.
  - `lbuf` is not reset.
- Reset asserted mid-row has the same effect as `cfg_start`, except `W` returns to 2.
- Latency: `out_valid` rises on the clk edge that samples the odd-row, odd-column input. The output is visible one cycle after that input's `in_valid` cycle. `out_valid` is high for exactly one cycle.
- Throughput: one input per cycle sustained. At most one output per two inputs, and outputs occur only on odd rows.
- `lbuf` write and read occur on different rows, so there is no same-cycle read/write hazard. `lbuf` is read combinationally.
- Signed comparison throughout: −128 < −1 < 0 < 127.

## Configuration
- `POOL_RELU_EN` defined:
  - Every accepted `in_data` is replaced by 0 when negative, before entering `hold` or the comparison path.
  - `out_data` is therefore always ≥ 0.
- Not defined: raw signed max pooling. Negative results pass through unchanged.

## Test plan
- **Basic 4×2 window.** Reset, then `cfg_start` with `cfg_cols=4`. Feed row0 = 1, 5, −3, 2 and row1 = 4, 0, 7, −8.
  - Required: `out_data=5` (`out_row_last=0`), then `7` (`out_row_last=1`).
  - Each output appears one cycle after the 2nd and 4th row1 samples.
- **Signed extremes** (W=2). Feed −128, −1, −128, −2.
  - Without the macro: `out_data=−1`.
  - With `POOL_RELU_EN`: `out_data=0`.
- **Gaps and back-to-back traffic.** Same stimulus as the basic window, with `in_valid` toggled 1/0 plus random multi-cycle idle gaps.
  - Required: identical outputs and order; `out_valid` pulses are never longer than 1 cycle.
- **Width wrap** (`cfg_cols=64`, MAX_COLS). Stream 4 rows with `sample = col − 32` (signed).
  - Required: 64 outputs with values −31, −29, …, 31.
  - `out_row_last` asserted on outputs 32 and 64.
- **Odd and illegal width.**
  - `cfg_cols=5` behaves exactly as 4.
  - `cfg_cols=0` or `1` behaves as 2.
  - `cfg_cols=100` behaves as 64.
- **Mid-row restart.** After 3 samples of row1, assert `cfg_start` with `in_valid=1` and `in_data=9`, then continue with a fresh W=2 frame: 9, 3 / 1, 2.
  - Required: no output from the aborted row; the next output is `out_data=9`.
  - Repeat the scenario with `reset` pulsed instead of `cfg_start`.
  - Required: all outputs are 0 during reset.

Source files
------------

// File: rtl/pe_maxpool2x2.sv
// Streaming 2x2 / stride-2 signed max-pooling stage fed by the PE result stream.
// Optional macro POOL_RELU_EN clamps negative input samples to zero before pooling.
module pe_maxpool2x2 #(
  parameter int DATA_W   = 8,
  parameter int MAX_COLS = 64,
  parameter int COL_W    = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_start,
  input  logic [COL_W-1:0]         cfg_cols,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_row_last
);

  localparam int HALF  = MAX_COLS / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [COL_W-1:0]         width_q, width_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic                     row_odd_q, row_odd_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic signed [DATA_W-1:0] out_data_d;
  logic                     out_valid_d, out_row_last_d;
  logic signed [DATA_W-1:0] lbuf [HALF];
  logic                     lbuf_we;

  logic [COL_W-1:0]         cfg_masked, cfg_width;
  logic [COL_W-1:0]         cur_col, cur_width;
  logic                     cur_row_odd;
  logic signed [DATA_W-1:0] cur_hold, sample, pair;
  logic [IDX_W-1:0]         idx;
  logic                     col_last;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Effective width: forced even, then clamped into [2, MAX_COLS].
  always_comb begin
    cfg_masked = cfg_cols & ~COL_W'(1);
    cfg_width  = cfg_masked;
    if (cfg_masked < COL_W'(2))
      cfg_width = COL_W'(2);
    else if (cfg_masked > COL_W'(MAX_COLS))
      cfg_width = COL_W'(MAX_COLS);
  end

  // A start pulse clears position state first, so a same-cycle sample lands at column 0 of row 0.
  always_comb begin
    cur_col     = cfg_start ? '0 : col_q;
    cur_row_odd = cfg_start ? 1'b0 : row_odd_q;
    cur_width   = cfg_start ? cfg_width : width_q;
    cur_hold    = cfg_start ? '0 : hold_q;
`ifdef POOL_RELU_EN
    sample      = in_data[DATA_W-1] ? '0 : in_data;
`else
    sample      = in_data;
`endif
    pair        = smax(cur_hold, sample);
    idx         = cur_col[IDX_W:1];
    col_last    = (cur_col == cur_width - COL_W'(1));
  end

  always_comb begin
    width_d        = cur_width;
    col_d          = cur_col;
    row_odd_d      = cur_row_odd;
    hold_d         = cur_hold;
    out_data_d     = out_data;
    out_valid_d    = 1'b0;
    out_row_last_d = 1'b0;
    lbuf_we        = 1'b0;
    if (in_valid) begin
      if (!cur_col[0]) begin
        hold_d = sample;
      end else if (!cur_row_odd) begin
        lbuf_we = reset;
      end else begin
        out_data_d     = smax(pair, lbuf[idx]);
        out_valid_d    = 1'b1;
        out_row_last_d = col_last;
      end
      if (col_last) begin
        col_d     = '0;
        row_odd_d = ~cur_row_odd;
      end else begin
        col_d = cur_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      width_q      <= COL_W'(2);
      col_q        <= '0;
      row_odd_q    <= 1'b0;
      hold_q       <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_row_last <= 1'b0;
    end else begin
      width_q      <= width_d;
      col_q        <= col_d;
      row_odd_q    <= row_odd_d;
      hold_q       <= hold_d;
      out_data     <= out_data_d;
      out_valid    <= out_valid_d;
      out_row_last <= out_row_last_d;
    end
  end

  // Line buffer is deliberately unreset; every entry is rewritten by an even row before use.
  always_ff @(posedge clk) begin
    if (lbuf_we)
      lbuf[idx] <= pair;
  end

endmodule
